// File: rtl/mdu_pkg.sv
// Shared op codes, op-class predicates and latency selection for the HI/LO multiply/divide unit.
// No logic of its own; the helpers are evaluated combinationally wherever they are called.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam int CNT_W = 6;

    typedef enum logic {ST_IDLE, ST_RUN} mdu_state_e;

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
        return (op >= OP_MADD) && (op <= OP_MSUBU);
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        return ((op >= OP_MULT) && (op <= OP_DIVU)) || is_acc(op);
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic [CNT_W-1:0] op_latency(input logic [3:0] op,
                                                    input int mul_cycles,
                                                    input int div_cycles);
        return is_div(op) ? CNT_W'(div_cycles) : CNT_W'(mul_cycles);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator: (un)signed multiply, multiply-accumulate and divide.
// Zero latency, no flow control; the owning pipe samples the result on issue.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    prod_u, prod_s, prod, acc, mac;
    logic [WIDTH-1:0] abs_rs, abs_rt, quo_u, rem_u, quo, rem;
    logic             neg_rs, neg_rt;

    always_comb begin
        prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};
        // Sign-extended operands give the two's-complement product modulo 2^(2*WIDTH).
        prod_s = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};
        prod   = is_signed(op) ? prod_s : prod_u;
        acc    = is_acc(op) ? {hi, lo} : '0;
        mac    = is_sub(op) ? (acc - prod) : (acc + prod);

        neg_rs = is_signed(op) & rs[WIDTH-1];
        neg_rt = is_signed(op) & rt[WIDTH-1];
        abs_rs = neg_rs ? (~rs + 1'b1) : rs;
        abs_rt = neg_rt ? (~rt + 1'b1) : rt;
        quo_u  = '0;
        rem_u  = '0;
        if (rt != '0) begin
            quo_u = abs_rs / abs_rt;
            rem_u = abs_rs % abs_rt;
        end
        // most-negative / -1 wraps back to most-negative with a zero remainder.
        quo = (neg_rs ^ neg_rt) ? (~quo_u + 1'b1) : quo_u;
        rem = neg_rs ? (~rem_u + 1'b1) : rem_u;

        if (is_div(op)) begin
            if (rt == '0) begin
                res_hi = rs;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end else begin
            {res_hi, res_lo} = mac;
        end
    end

endmodule

// File: rtl/mdu_pipe.sv
// E-stage multiply/divide unit owning HI/LO. Latency: MUL_CYCLES or DIV_CYCLES busy cycles after issue.
// Backpressure: busy drives the stall unit; issue is dropped while busy or when req is high.
module mdu_pipe
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic             req,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic [WIDTH-1:0] md_out
);

    mdu_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, res_hi, res_lo, calc_hi, calc_lo;
    logic             issue, start, done;

    assign issue = op_valid & ~req & (state == ST_IDLE);
    assign start = issue & is_long_op(op);
    assign done  = (state == ST_RUN) && (cnt == '0);

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .hi     (hi),
        .lo     (lo),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (done)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
    end

    // The result is captured at issue so accumulates use HI/LO as they were then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (start) begin
                res_hi <= calc_hi;
                res_lo <= calc_lo;
                cnt    <= op_latency(op, MUL_CYCLES, DIV_CYCLES) - 1'b1;
            end else if ((state == ST_RUN) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (done) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (issue && (op == OP_MTHI)) begin
                hi <= rs;
            end else if (issue && (op == OP_MTLO)) begin
                lo <= rs;
            end
        end
    end

    always_comb begin
        md_out = '0;
        if (op == OP_MFHI)      md_out = hi;
        else if (op == OP_MFLO) md_out = lo;
    end

endmodule

// File: tb/tb_mdu_pipe.sv
// Drives a default-latency and a single-cycle-latency mdu_pipe with shared stimulus and
// compares both against an arithmetic model of HI/LO and the expected busy window.
module tb_mdu_pipe;

    localparam int L_MUL = 5;
    localparam int L_DIV = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        req;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        busy_s, busy_f;
    logic [31:0] md_s, md_f;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_pipe #(.WIDTH(32), .MUL_CYCLES(L_MUL), .DIV_CYCLES(L_DIV)) u_slow (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .req(req),
        .rs(rs), .rt(rt), .busy(busy_s), .md_out(md_s)
    );

    mdu_pipe #(.WIDTH(32), .MUL_CYCLES(1), .DIV_CYCLES(1)) u_fast (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .req(req),
        .rs(rs), .rt(rt), .busy(busy_f), .md_out(md_f)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_long(input logic [3:0] o);
        return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd9 && o <= 4'd12);
    endfunction

    // {HI,LO} after an op, from plain 64-bit arithmetic.
    function automatic logic [63:0] model_apply(input logic [3:0] o, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sb, q, r;
        logic [63:0] sp, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        case (o)
            4'd1:  return sp;
            4'd2:  return up;
            4'd9:  return acc + sp;
            4'd10: return acc + up;
            4'd11: return acc - sp;
            4'd12: return acc - up;
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    task automatic read_hilo(input string tag);
        op_valid = 1'b0;
        op = 4'd5; #1;
        check_eq({tag, "_hi_s"}, md_s, m_hi);
        check_eq({tag, "_hi_f"}, md_f, m_hi);
        op = 4'd6; #1;
        check_eq({tag, "_lo_s"}, md_s, m_lo);
        check_eq({tag, "_lo_f"}, md_f, m_lo);
        op = 4'd0; #1;
        check_eq({tag, "_none"}, md_s, 0);
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        op = 4'd5; #1;
        check_eq({tag, "_hi"}, md_s, hi);
        op = 4'd6; #1;
        check_eq({tag, "_lo"}, md_s, lo);
        op = 4'd0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit rq, input int req_at);
        logic [63:0] old_v, new_v;
        int          ls;
        @(negedge clk);
        op_valid = 1'b1; op = o; rs = a; rt = b; req = rq;
        @(negedge clk);
        op_valid = 1'b0; op = 4'd5; req = 1'b0;
        old_v = {m_hi, m_lo};
        new_v = old_v;
        if (!rq && is_long(o)) new_v = model_apply(o, a, b, old_v);
        else if (!rq && o == 4'd7) new_v[63:32] = a;
        else if (!rq && o == 4'd8) new_v[31:0] = a;
        if (!rq && is_long(o)) begin
            ls = (o == 4'd3 || o == 4'd4) ? L_DIV : L_MUL;
            for (int k = 0; k < ls + 2; k++) begin
                #1;
                check_eq("busy_s", busy_s, k < ls);
                check_eq("busy_f", busy_f, k < 1);
                check_eq("hold_s", md_s, (k < ls) ? old_v[63:32] : new_v[63:32]);
                check_eq("hold_f", md_f, (k < 1) ? old_v[63:32] : new_v[63:32]);
                req = (k == req_at);
                @(negedge clk);
            end
            req = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                #1;
                check_eq("idle_busy_s", busy_s, 0);
                check_eq("idle_busy_f", busy_f, 0);
                @(negedge clk);
            end
        end
        {m_hi, m_lo} = new_v;
        read_hilo("rd");
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; op_valid = 1'b0; req = 1'b0; op = 4'd0; rs = '0; rt = '0;
        m_hi = '0; m_lo = '0;
        #1;
        check_eq("rst_busy_s", busy_s, 0);
        check_eq("rst_busy_f", busy_f, 0);
        read_hilo("rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 0, -1);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1);
        issue(4'd10, 32'd1, 32'd1, 0, -1);
        expect_hilo("maddu", 32'hFFFF_FFFE, 32'h0000_0002);
        issue(4'd11, 32'd2, 32'd1, 0, -1);
        expect_hilo("msub", 32'hFFFF_FFFE, 32'h0000_0000);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 0, -1);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(4'd4, 32'd5, 32'd0, 0, -1);
        expect_hilo("divu0", 32'd5, 32'hFFFF_FFFF);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1);
        expect_hilo("divovf", 32'd0, 32'h8000_0000);
        issue(4'd1, 32'd7, 32'd9, 1, -1);
        expect_hilo("req_mult", 32'd0, 32'h8000_0000);
        issue(4'd8, 32'h1234, 32'd0, 1, -1);
        issue(4'd8, 32'h1234, 32'd0, 0, -1);
        expect_hilo("mtlo", 32'd0, 32'h1234);
        issue(4'd3, 32'd100, 32'd7, 0, 2);
        expect_hilo("div_req", 32'd2, 32'd14);

        // Abort a divide mid-run with an asynchronous reset between clock edges.
        @(negedge clk);
        op_valid = 1'b1; op = 4'd3; rs = 32'd50; rt = 32'd3;
        @(negedge clk);
        op_valid = 1'b0; op = 4'd5;
        repeat (3) @(negedge clk);
        #2;
        check_eq("pre_rst_busy", busy_s, 1);
        reset = 1'b0; #1;
        check_eq("arst_busy_s", busy_s, 0);
        check_eq("arst_busy_f", busy_f, 0);
        check_eq("arst_hi", md_s, 0);
        op = 4'd6; #1;
        check_eq("arst_lo", md_s, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b1;

        issue(4'd1, 32'd3, 32'd4, 0, -1);
        expect_hilo("mult12", 32'd0, 32'd12);

        for (int n = 0; n < 300; n++) begin
            issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multiply/divide unit for the E stage of the 5-stage core; owns the HI/LO registers.
- Supports signed/unsigned mult/div, plus multiply-accumulate (MADD/MADDU/MSUB/MSUBU), which the current unit does not.
- Multiply and divide latencies are independent parameters.
- Issue is suppressed when the CP0 exception request `req` is high in the issue cycle.

Parameters:
- WIDTH, 32: operand, HI and LO width.
- MUL_CYCLES, 5: busy cycles for MULT/MULTU/MADD*/MSUB*; legal range 1..15.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; legal range 1..63.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- op_valid  in  1  an MDU instruction is in E this cycle.
- op  in  4  operation code from mdu_pkg.
- req  in  1  CP0 exception/interrupt request; blocks issue this cycle.
- rs  in  WIDTH  forwarded rs operand.
- rt  in  WIDTH  forwarded rt operand.
- busy  out  1  long operation in progress.
- md_out  out  WIDTH  HI for MFHI, LO for MFLO, else 0.

Behaviour:
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12. Codes 13-15 are treated as NONE.
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, cnt=0, state=IDLE, md_out=0.
- issue = op_valid & !req & (state==IDLE). In any other case the op is ignored; the stall unit guarantees no long op arrives while busy.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN on issue of a long op (MULT..DIVU, MADD..MSUBU).
  - On that edge: latch the computed result into res_hi/res_lo; cnt <= latency-1.
  - RUN: cnt decrements each cycle. When cnt==0: HI<=res_hi, LO<=res_lo, and state returns to IDLE on that same edge.
  - busy = (state==RUN). It is high for exactly MUL_CYCLES or DIV_CYCLES cycles, starting the cycle after issue.
  - HI/LO hold their old values while busy.
- Arithmetic:
  - MULT is the signed 2*WIDTH product and MULTU the unsigned product. {HI,LO} = product.
  - MADD/MSUB: {HI,LO} := {HI,LO} ± signed product. MADDU/MSUBU use the unsigned product. Arithmetic is modulo 2^(2*WIDTH).
  - The accumulate operand is the {HI,LO} value at issue, not at completion.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = rs.
  - Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- MTHI/MTLO: on issue, HI (or LO) <= rs on that edge. The unit stays IDLE and busy stays 0.
- MFHI/MFLO: md_out is combinational from the current HI/LO whenever op is MFHI/MFLO, regardless of op_valid, req or busy. The stall unit prevents reads while busy.
- req while in RUN does not abort: the issuing instruction has already left E and is committed, so the result still retires.
- A reset assertion during RUN aborts immediately: HI/LO are cleared and busy goes to 0.

Decomposition:
- mdu_pkg holds:
  - the op-code constants, plus the predicates is_long_op, is_div, is_signed and is_acc;
  - a helper that selects latency (MUL_CYCLES/DIV_CYCLES) per op;
  - the LATENCY counter width of 6 bits.
- Sub-module mdu_arith: purely combinational. Inputs are op, rs, rt, HI and LO; outputs are res_hi and res_lo.
  - Contains the signed/unsigned multiply, the accumulate add/sub, and division with the zero and overflow rules.
  - Keeps mdu_pipe limited to the FSM, counter and HI/LO state.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 at default params -> busy high for exactly 5 cycles from the next cycle; after that HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO gives md_out=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, then MADDU rs=1, rt=1 after idle -> HI=0xFFFFFFFE, LO=0x00000002. Then MSUB rs=2, rt=1 -> HI=0xFFFFFFFE, LO=0x00000000.
- DIV rs=-7, rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- op_valid=1, op=MULT, req=1 in the same cycle -> busy stays 0, HI/LO unchanged. MTLO rs=0x1234 with req=1 -> LO unchanged; with req=0 -> LO=0x1234 next edge, busy never asserts.
- Issue DIV, then req=1 in its third busy cycle -> completes on schedule with the correct result. Separately, drive reset=0 mid-RUN -> busy=0, HI=LO=0 immediately (asynchronous, without a clock edge).
- Re-parametrise MUL_CYCLES=1, DIV_CYCLES=1: MULT 3*4 -> busy high for one cycle, LO=12 the cycle after. Back-to-back MFLO -> md_out=12.
